quadrilatero_lsu_row_packer: RTL

Sits directly downstream of the LSU load FIFO. It pops DATA_WIDTH-bit words from the LSU output head and packs them into RLEN-bit matrix register rows. Each completed row is written into the matrix register file through a request/grant write port. One start pulse loads up to N_ROWS rows of a single matrix register.

---
 rtl/quadrilatero_lsu_row_packer_if.sv | 36 +++
 rtl/quadrilatero_lsu_row_packer.sv | 107 ++++++++++
 2 files changed

// File: rtl/quadrilatero_lsu_row_packer_if.sv
// Bundle of the control, LSU-pop and register-file write signals of the row packer.
// The packer takes the slave side; whatever drives loads and serves the RF takes the master side.
interface quadrilatero_lsu_row_packer_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RLEN       = 128,
   parameter int unsigned N_REGS     = 8,
   parameter int unsigned N_ROWS     = 4
);
   localparam int unsigned RW   = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam int unsigned ROWW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
   localparam int unsigned CNTW = $clog2(N_ROWS + 1);

   logic                  start_i;
   logic [RW-1:0]         reg_i;
   logic [CNTW-1:0]       rows_i;
   logic                  busy_o;
   logic                  done_o;
   logic [DATA_WIDTH-1:0] lsu_data_i;
   logic                  lsu_data_available_i;
   logic                  lsu_pop_o;
   logic                  rf_we_o;
   logic [RW-1:0]         rf_reg_o;
   logic [ROWW-1:0]       rf_row_o;
   logic [RLEN-1:0]       rf_wdata_o;
   logic                  rf_gnt_i;

   modport slave (
      input  start_i, reg_i, rows_i, lsu_data_i, lsu_data_available_i, rf_gnt_i,
      output busy_o, done_o, lsu_pop_o, rf_we_o, rf_reg_o, rf_row_o, rf_wdata_o
   );

   modport master (
      output start_i, reg_i, rows_i, lsu_data_i, lsu_data_available_i, rf_gnt_i,
      input  busy_o, done_o, lsu_pop_o, rf_we_o, rf_reg_o, rf_row_o, rf_wdata_o
   );
endinterface

// File: rtl/quadrilatero_lsu_row_packer.sv
// Packs DATA_WIDTH-bit LSU words into RLEN-bit matrix rows and writes each row to the
// matrix register file; one start loads up to N_ROWS rows of one register.
module quadrilatero_lsu_row_packer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RLEN       = 128,
   parameter int unsigned N_REGS     = 8,
   parameter int unsigned N_ROWS     = 4
) (
   input logic                          clk_i,
   input logic                          rst_ni,
   quadrilatero_lsu_row_packer_if.slave bus
);
   localparam int unsigned WORDS = RLEN / DATA_WIDTH;
   localparam int unsigned RW    = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam int unsigned ROWW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
   localparam int unsigned CNTW  = $clog2(N_ROWS + 1);
   localparam int unsigned WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_e;

   state_e          state_q, state_d;
   logic [WCW-1:0]  word_cnt_q, word_cnt_d;
   logic [ROWW-1:0] row_cnt_q, row_cnt_d;
   logic [RLEN-1:0] buf_q, buf_d;
   logic [RW-1:0]   reg_q, reg_d;
   logic [CNTW-1:0] rows_q, rows_d;

   // NOTE: the row buffer is a plain register, not a RAM, so it is reset with the rest
   // of the state; a reset load can never leak stale data onto rf_wdata_o.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         word_cnt_q <= '0;
         row_cnt_q  <= '0;
         buf_q      <= '0;
         reg_q      <= '0;
         rows_q     <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         row_cnt_q  <= row_cnt_d;
         buf_q      <= buf_d;
         reg_q      <= reg_d;
         rows_q     <= rows_d;
      end
   end

   always_comb begin
      // NOTE: hold-value defaults first, so no path through the case infers a latch.
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      row_cnt_d  = row_cnt_q;
      buf_d      = buf_q;
      reg_d      = reg_q;
      rows_d     = rows_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               if (bus.rows_i == '0) begin
                  state_d = DONE;
               end else begin
                  state_d    = COLLECT;
                  reg_d      = bus.reg_i;
                  rows_d     = (bus.rows_i > CNTW'(N_ROWS)) ? CNTW'(N_ROWS) : bus.rows_i;
                  word_cnt_d = '0;
                  row_cnt_d  = '0;
               end
            end
         end
         COLLECT: begin
            if (bus.lsu_data_available_i) begin
               buf_d[32'(word_cnt_q) * DATA_WIDTH +: DATA_WIDTH] = bus.lsu_data_i;
               if (word_cnt_q == WCW'(WORDS - 1)) begin
                  word_cnt_d = '0;
                  state_d    = WRITE;
               end else begin
                  word_cnt_d = word_cnt_q + WCW'(1);
               end
            end
         end
         WRITE: begin
            if (bus.rf_gnt_i) begin
               if (CNTW'(row_cnt_q) == rows_q - CNTW'(1)) begin
                  state_d = DONE;
               end else begin
                  row_cnt_d = row_cnt_q + ROWW'(1);
                  state_d   = COLLECT;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Write-port fields are gated to zero outside WRITE so the RF sees a quiet bus.
   always_comb begin
      bus.busy_o     = (state_q != IDLE);
      bus.done_o     = (state_q == DONE);
      bus.lsu_pop_o  = (state_q == COLLECT) && bus.lsu_data_available_i;
      bus.rf_we_o    = (state_q == WRITE);
      bus.rf_reg_o   = (state_q == WRITE) ? reg_q : '0;
      bus.rf_row_o   = (state_q == WRITE) ? row_cnt_q : '0;
      bus.rf_wdata_o = (state_q == WRITE) ? buf_q : '0;
   end
endmodule
